csa_accumulator: RTL
====================

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameter N, default 4: unsigned operand width in bits.
REQ-002 Parameter G, default 4: guard bits; accumulator width W = N+G.
REQ-003 Parameter CHUNK, default 4: bits resolved per carry-propagate cycle; W SHALL be a multiple of CHUNK (elaboration error otherwise).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  N  unsigned operand, zero-extended to W.
REQ-009 in_last  input  1  marks final beat of a frame; qualified by in_valid & in_ready.
REQ-010 out_valid  output  1  resolved frame sum available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  W  frame sum modulo 2^W.
REQ-013 out_ovf  output  1  frame sum exceeded 2^W-1.

Function
REQ-014 The block SHALL hold the running total in redundant form: registers S[W-1:0] and C[W-1:0], plus a sticky ovf flag.
REQ-015 States SHALL be ACCUM, RESOLVE, DONE; in_ready = 1 only in ACCUM; out_valid = 1 only in DONE.
REQ-016 On an accepted beat: S <= S^C^x; C <= maj(S,C,x)<<1; ovf <= ovf | maj(S,C,x)[W-1]; no carry propagation in this cycle.
REQ-017 An accepted beat with in_last=1 SHALL be accumulated and then move ACCUM -> RESOLVE.
REQ-018 RESOLVE SHALL ripple-add S+C over W/CHUNK cycles, least-significant chunk first, with the inter-chunk carry registered; the final carry-out SHALL be ORed into ovf; then RESOLVE -> DONE.
REQ-019 Latency: last beat accepted at edge t -> out_valid high after edge t+W/CHUNK+1 (t+3 for defaults).
REQ-020 In DONE, out_sum and out_ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 On out_valid & out_ready: S, C, ovf cleared to 0, DONE -> ACCUM; in_ready is high on the following cycle, not the same cycle.
REQ-022 in_valid while in_ready=0 SHALL be ignored and produce no state change.
REQ-023 A single-beat frame (in_last on first beat) SHALL be legal; empty frames do not exist.
REQ-024 out_sum SHALL equal the sum of the frame's operands mod 2^W; out_ovf SHALL be 1 iff the true sum >= 2^W.

Reset
REQ-025 rst_n low SHALL immediately force state ACCUM, S=C=0, ovf=0, chunk index and carry 0, out_valid=0, in_ready=1 after release, out_sum=0, out_ovf=0.
REQ-026 Reset asserted in any state, including mid-RESOLVE or DONE, SHALL discard the frame with no partial output.

Configuration
REQ-027 Macro CSA_ACC_SINGLE_CYCLE_CPA_EN: when defined, RESOLVE SHALL last exactly one cycle using a full W-bit add (latency t+2) and CHUNK is ignored; when undefined, chunked resolution per REQ-018 applies.

Verification (N=4, G=4, CHUNK=4, macro undefined unless stated)
REQ-028 Frame {3,5,6} -> out_sum=0x0E, out_ovf=0.
REQ-029 Frames {15,1,1} then {9,9,9} back-to-back -> out_sum=0x11 then 0x1B, ovf=0 both, S/C cleared between frames.
REQ-030 17 beats of 15 -> out_sum=0xFF, ovf=0; 18 beats of 15 -> out_sum=0x0E, ovf=1.
REQ-031 Single beat {7}, last accepted at edge t -> out_valid first high after edge t+3; with CSA_ACC_SINGLE_CYCLE_CPA_EN defined, after edge t+2.
REQ-032 out_ready held low 5 cycles in DONE -> out_valid stays 1, out_sum stable, in_ready 0, in_valid beats ignored.
REQ-033 rst_n pulsed low during RESOLVE of {3,5,6} -> out_valid never rises for it; next frame {1} -> out_sum=0x01, ovf=0.

Source files
------------

// File: rtl/csa_accumulator_if.sv
// Handshake bundle for csa_accumulator: operand stream in, resolved frame sum out.
// The design is the slave; the producer/consumer side uses the master modport.
interface csa_accumulator_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/csa_accumulator.sv
// Frame accumulator: carry-save running total, chunked carry-propagate resolve at frame end.
// Define CSA_ACC_SINGLE_CYCLE_CPA_EN to resolve with one full-width add instead of CHUNK-wide steps.
module csa_accumulator #(
  parameter int N     = 4,
  parameter int G     = 4,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  csa_accumulator_if.slave bus
);
  localparam int W = N + G;

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

  state_t       state_reg;
  logic [W-1:0] s_reg;
  logic [W-1:0] c_reg;
  logic [W-1:0] sum_reg;
  logic [W-1:0] out_sum_reg;
  logic         ovf_reg;
  logic         carry_reg;
  logic         cpa_done_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         out_ovf_reg;

  logic [W-1:0] x;
  logic [W-1:0] maj;
  logic         accept;

  assign x      = W'(bus.in_data);
  assign maj    = (s_reg & c_reg) | (s_reg & x) | (c_reg & x);
  assign accept = bus.in_valid & in_ready_reg;

`ifdef CSA_ACC_SINGLE_CYCLE_CPA_EN
  logic [W:0] full_add;
  assign full_add = {1'b0, s_reg} + {1'b0, c_reg};
`else
  localparam int NCH = W / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if ((W % CHUNK) != 0) begin : g_chunk_check
      $error("csa_accumulator: W=%0d is not a multiple of CHUNK=%0d", W, CHUNK);
    end
  endgenerate

  logic [IW-1:0] idx_reg;
  logic [CHUNK:0] chunk_add;
  // S and C shift right each step, so the low chunk is always the one being resolved.
  assign chunk_add = {1'b0, s_reg[CHUNK-1:0]} + {1'b0, c_reg[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_reg};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      s_reg         <= '0;
      c_reg         <= '0;
      sum_reg       <= '0;
      out_sum_reg   <= '0;
      ovf_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      cpa_done_reg  <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
`ifndef CSA_ACC_SINGLE_CYCLE_CPA_EN
      idx_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            s_reg   <= s_reg ^ c_reg ^ x;
            c_reg   <= maj << 1;
            ovf_reg <= ovf_reg | maj[W-1];
            if (bus.in_last) begin
              state_reg    <= RESOLVE;
              in_ready_reg <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          if (cpa_done_reg) begin
            out_sum_reg   <= sum_reg;
            out_ovf_reg   <= ovf_reg | carry_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
`ifdef CSA_ACC_SINGLE_CYCLE_CPA_EN
            sum_reg      <= full_add[W-1:0];
            carry_reg    <= full_add[W];
            cpa_done_reg <= 1'b1;
`else
            sum_reg   <= (sum_reg >> CHUNK) | (W'(chunk_add[CHUNK-1:0]) << (W - CHUNK));
            s_reg     <= s_reg >> CHUNK;
            c_reg     <= c_reg >> CHUNK;
            carry_reg <= chunk_add[CHUNK];
            if (idx_reg == IW'(NCH - 1)) begin
              cpa_done_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            s_reg         <= '0;
            c_reg         <= '0;
            sum_reg       <= '0;
            ovf_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            cpa_done_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ACCUM;
`ifndef CSA_ACC_SINGLE_CYCLE_CPA_EN
            idx_reg       <= '0;
`endif
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_ovf   = out_ovf_reg;
endmodule
